// File: rtl/mix_columns_iter_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES MixColumns stage.
package mix_columns_iter_pkg;

    typedef logic [7:0]    byte_t;
    typedef byte_t [3:0]   column_t;
    typedef logic [127:0]  state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_t;

    localparam byte_t AES_POLY = 8'h1B;

    // Element [3-k] is the coefficient applied to byte a_(i+k).
    localparam column_t FWD_COEFF = {8'h02, 8'h03, 8'h01, 8'h01};
    localparam column_t INV_COEFF = {8'h0E, 8'h0B, 8'h0D, 8'h09};

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic byte_t mul_byte(input byte_t a, input byte_t b);
        byte_t p;
        byte_t x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? (p ^ x) : p;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/mix_columns_iter_mix_column.sv
// Combinational MixColumns / InvMixColumns of one 32-bit column (element [3] is row 0).
module mix_column
    import mix_columns_iter_pkg::*;
#(
    parameter bit inverse = 1'b0
) (
    input  column_t col_i,
    output column_t col_o
);

    localparam column_t COEFF = inverse ? INV_COEFF : FWD_COEFF;

    function automatic byte_t mix_row(input column_t a, input int r);
        byte_t acc;
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
            acc = acc ^ mul_byte(a[2'd3 - 2'(r + k)], COEFF[2'd3 - 2'(k)]);
        end
        return acc;
    endfunction

    // Every output row is a fixed linear combination of the four input rows.
    always_comb begin
        col_o = '0;
        for (int r = 0; r < 4; r++) begin
            col_o[2'd3 - 2'(r)] = mix_row(col_i, r);
        end
    end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns: one column per clock, one state in flight, valid/ready on both sides.
module mix_columns_iter
    import mix_columns_iter_pkg::*;
#(
    parameter bit inverse = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    fsm_t        state_q;
    logic [1:0]  col_q;
    state_t      work_q;
    state_t      work_d;
    logic        in_ready_q;
    logic        out_valid_q;
    column_t     cur_col_s;
    column_t     mixed_col_s;

    // Column c occupies bits [127-32c -: 32].
    always_comb begin
        cur_col_s = work_q[7'd127 - {col_q, 5'd0} -: 32];
    end

    mix_column #(.inverse(inverse)) u_mix_column (
        .col_i (cur_col_s),
        .col_o (mixed_col_s)
    );

    // Overwrite only the current column; untouched columns keep their input values.
    always_comb begin
        work_d = work_q;
        if (state_q == BUSY) begin
            work_d[7'd127 - {col_q, 5'd0} -: 32] = mixed_col_s;
        end else begin
            work_d = work_q;
        end
    end

    // Control FSM with registered handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= 2'd0;
            work_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q     <= in_data;
                        col_q      <= 2'd0;
                        state_q    <= BUSY;
                        in_ready_q <= 1'b0;
                    end
                end
                BUSY: begin
                    work_q <= work_d;
                    if (col_q == 2'd3) begin
                        col_q       <= 2'd0;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        col_q <= col_q + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    col_q       <= 2'd0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = work_q;

endmodule
